// File: rtl/jzjpcc_mem_arbiter.sv
// jzjpcc_mem_arbiter: shares one single-port sync RAM between the
// fetch port (reads) and the data port (loads/stores).
//
// Ports:
//   clock, reset           clock; async active-high reset
//   fetch_req/addr         fetch read request (held until ready)
//   fetch_ready            fetch accepted this cycle
//   fetch_rvalid/rdata     fetch read return, 1 cycle after accept
//   data_req/we/addr       data request (we=1 store, 0 load)
//   data_wdata/bytemask    store data and byte enables
//   data_ready             data accepted this cycle
//   data_rvalid/rdata      load return, 1 cycle after accept
//   ram_addr/we/wdata/
//   ram_bytemask           RAM request from the granted port
//   ram_rdata              RAM read data, 1 cycle after address
//
// Build option: JZJPCC_MEM_ARBITER_STARVATION_GUARD_EN forces a
// fetch grant after STARVE_LIMIT consecutive contended denials.
// Without it the data port has strict priority.

module jzjpcc_mem_arbiter #(
  parameter int MEM_ADDR_B   = 12,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [MEM_ADDR_B-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_rvalid,
  output logic [31:0]           fetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [MEM_ADDR_B-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  input  logic [3:0]            data_bytemask,
  output logic                  data_ready,
  output logic                  data_rvalid,
  output logic [31:0]           data_rdata,
  output logic [MEM_ADDR_B-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_bytemask,
  input  logic [31:0]           ram_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadLimit
    $error("STARVE_LIMIT must be 1..15");
  end

  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } owner_t;

  logic   grantFetch;
  logic   grantData;
  logic   forceFetch;
  logic   pending;
  owner_t owner;

`ifdef JZJPCC_MEM_ARBITER_STARVATION_GUARD_EN
  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] starveCnt;

  assign forceFetch = starveCnt >= Limit;

  // Counts consecutive contended cycles that fetch lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starveCnt <= '0;
    end else if (!fetch_req || grantFetch) begin
      starveCnt <= '0;
    end else if (data_req && grantData
                 && starveCnt != 4'hF) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end
`else
  assign forceFetch = 1'b0;
`endif

  // Data wins contention unless the guard says fetch
  // has waited long enough.
  always_comb begin
    grantFetch = 1'b0;
    grantData  = 1'b0;
    if (!reset) begin
      if (data_req && !(fetch_req && forceFetch)) begin
        grantData = 1'b1;
      end else if (fetch_req) begin
        grantFetch = 1'b1;
      end
    end
  end

  assign fetch_ready = grantFetch;
  assign data_ready  = grantData;

  always_comb begin
    ram_addr     = fetch_addr;
    ram_we       = 1'b0;
    ram_wdata    = 32'h0;
    ram_bytemask = 4'b0000;
    if (grantData) begin
      ram_addr     = data_addr;
      ram_we       = data_we;
      ram_wdata    = data_wdata;
      ram_bytemask = data_bytemask;
    end
  end

  // Stores never return data, so only reads mark a
  // return as pending for the next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      owner   <= OwnFetch;
    end else begin
      pending <= grantFetch || (grantData && !data_we);
      owner   <= grantData ? OwnData : OwnFetch;
    end
  end

  assign fetch_rvalid = pending && (owner == OwnFetch);
  assign data_rvalid  = pending && (owner == OwnData);
  assign fetch_rdata  = fetch_rvalid ? ram_rdata : 32'h0;
  assign data_rdata   = data_rvalid ? ram_rdata : 32'h0;

endmodule

// File: doc/jzjpcc_mem_arbiter.md
# jzjpcc_mem_arbiter

Arbitrates one single-port synchronous RAM between two requesters: the fetch port (read-only, instruction words) and the data port (loads and stores issued by the memory stage using the execute stage's word address, write data and byte mask). At most one access is granted per cycle. Read data returns one cycle after acceptance and is steered to the requester that issued it. The block sits between the pipeline stages and the shared RAM; its ready outputs are used by the pipeline as stall conditions.

## Interface
- MEM_ADDR_B, 12: word-address width; the RAM holds 2^MEM_ADDR_B 32-bit words.
- STARVE_LIMIT, 3: consecutive fetch denials tolerated before fetch is forced to win (guard builds only); legal range 1..15.

- clock  in  1  system clock; reset  in  1  asynchronous, active-high
- fetch_req  in  1  fetch read request; held until accepted
- fetch_addr  in  MEM_ADDR_B  fetch word address
- fetch_ready  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  fetch_rdata valid
- fetch_rdata  out  32  instruction word
- data_req  in  1  data request; held until accepted
- data_we  in  1  1 = store, 0 = load
- data_addr  in  MEM_ADDR_B  data word address (aluResult[MEM_ADDR_B+1:2])
- data_wdata  in  32  store data, already lane-aligned
- data_bytemask  in  4  store byte enables; bit i covers bits 8i+7:8i
- data_ready  out  1  data request accepted this cycle
- data_rvalid  out  1  data_rdata valid (loads only)
- data_rdata  out  32  load word
- ram_addr  out  MEM_ADDR_B  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_bytemask  out  4  RAM byte enables
- ram_rdata  in  32  RAM read data, valid the cycle after the address is presented

## Operation
- Grant is combinational from fetch_req, data_req and the starvation counter. A request is accepted on a rising edge where req && ready.
- Only data_req: data granted. Only fetch_req: fetch granted. Both: data granted unless the guard forces fetch. Neither: no grant, ram_we = 0.
- ram_addr, ram_we, ram_wdata and ram_bytemask are driven from the granted port. If fetch is granted, or nothing is granted, ram_we = 0 and ram_bytemask = 4'b0000.
- Accepted reads set a registered owner bit (fetch or data) and a pending flag. No pending entry is created for stores.
- In the next cycle, the owner's rvalid = 1 and its rdata = ram_rdata. The other port's rvalid = 0 and its rdata = 32'h0.
- Back-to-back reads are allowed every cycle, with no bubble. The owner and pending flag update every edge.
- Store followed by a load to the same address: the load returns the new data. The RAM is write-first and the block adds no bypass.
- Starvation counter, 4 bits: increments on each edge where fetch_req && data_req && data granted. It clears on any edge where fetch is accepted, or where fetch_req = 0.

## Timing
- Reset values: fetch_rvalid = 0, data_rvalid = 0, fetch_rdata = 0, data_rdata = 0, pending = 0, owner = fetch, counter = 0.
- While reset is asserted: fetch_ready = 0, data_ready = 0, ram_we = 0.
- Accept latency is 0 cycles (ready in the same cycle as req). Read latency is 1 cycle from the accepting edge to rvalid.
- Reset asserted with a read pending: the read is dropped and no rvalid is ever produced for it.
- A requester must hold its address and data stable while req = 1 and ready = 0. The arbiter never retracts ready within a cycle.

## Configuration
- JZJPCC_MEM_ARBITER_STARVATION_GUARD_EN defined: when the counter reaches STARVE_LIMIT, the next contended cycle grants fetch. That acceptance clears the counter.
- Macro undefined: strict data priority. The counter logic is removed. Fetch may wait indefinitely while data_req stays high.

## Test plan
- Fetch-only: fetch_req = 1, fetch_addr = 0x010, RAM[0x010] = 0x00500093 -> fetch_ready = 1 the same cycle; next cycle fetch_rvalid = 1, fetch_rdata = 0x00500093, data_rvalid = 0.
- Store then load: data store to 0x020, wdata = 0xAABBCCDD, mask = 4'b0101, old word 0x11223344; then load 0x020 -> data_rdata = 0x11BB33DD one cycle after the load is accepted.
- Contention: fetch_req and data_req (load 0x030) both high for one cycle -> data_ready = 1, fetch_ready = 0; fetch is accepted the following cycle after data_req drops. rvalid pulses are ordered data, then fetch.
- Starvation, guard built, STARVE_LIMIT = 3: both requests held high for 6 cycles -> grant order is D, D, D, F, D, D. Guard not built: D for all 6 cycles.
- Reset mid-read: fetch read accepted, reset asserted before the next edge -> fetch_rvalid stays 0, counter = 0, ready outputs = 0 while reset is high.
- Back-to-back reads: fetch at 0x000 and 0x001 on consecutive cycles, then a data load at 0x002 -> three consecutive rvalid pulses, each with the correct port and word.
